// File: rtl/mac_const.sv
// rtl/mac_const.sv - shared constants for the segmented MAC accumulator
package mac_const;

  localparam logic [1:0] MAC_MODE_1X = 2'b00;
  localparam logic [1:0] MAC_MODE_2X = 2'b01;
  localparam logic [1:0] MAC_MODE_4X = 2'b10;

  localparam int MAC_LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } mac_state_t;

endpackage

// File: rtl/mac_seg_adder.sv
// rtl/mac_seg_adder.sv - lane-segmented adder with per-lane carry vector
// Saturating lanes when MAC_ACC_SAT_EN is defined.
module mac_seg_adder
  import mac_const::*;
#(
  parameter int MIN_W = 8
) (
  input  logic [4*MIN_W-1:0]     a,
  input  logic [4*MIN_W-1:0]     b,
  input  logic                   cin,
  input  logic [1:0]             mode,
  output logic [4*MIN_W-1:0]     sum,
  output logic [MAC_LANES-1:0]   carry
);

  logic [MAC_LANES-1:0] seg_c;
  logic [MIN_W:0]       seg_tmp;
  logic                 chain;

  // Add one byte segment at a time so the chain can be cut at any lane edge.
  always_comb begin
    sum     = '0;
    seg_c   = '0;
    seg_tmp = '0;
    chain   = cin;
    for (int k = 0; k < MAC_LANES; k++) begin
      seg_tmp = {1'b0, a[k*MIN_W +: MIN_W]} + {1'b0, b[k*MIN_W +: MIN_W]}
              + {{MIN_W{1'b0}}, chain};
      sum[k*MIN_W +: MIN_W] = seg_tmp[MIN_W-1:0];
      seg_c[k] = seg_tmp[MIN_W];
      if (mode == MAC_MODE_4X)
        chain = 1'b0;
      else if (mode == MAC_MODE_2X && k == 1)
        chain = 1'b0;
      else
        chain = seg_c[k];
    end
`ifdef MAC_ACC_SAT_EN
    for (int k = 0; k < MAC_LANES; k++) begin
      if (mode == MAC_MODE_4X) begin
        if (seg_c[k]) sum[k*MIN_W +: MIN_W] = '1;
      end else if (mode == MAC_MODE_2X) begin
        if (seg_c[k | 1]) sum[k*MIN_W +: MIN_W] = '1;
      end else begin
        if (seg_c[3]) sum[k*MIN_W +: MIN_W] = '1;
      end
    end
`endif
  end

  // Reserved mode 11 behaves as a single 32-bit lane.
  always_comb begin
    case (mode)
      MAC_MODE_4X: carry = seg_c;
      MAC_MODE_2X: carry = {2'b00, seg_c[3], seg_c[1]};
      default:     carry = {3'b000, seg_c[3]};
    endcase
  end

endmodule

// File: rtl/mac_accumulate_seg.sv
// rtl/mac_accumulate_seg.sv - segmented MAC accumulator with valid/ready job control
// Optional unsigned lane saturation: MAC_ACC_SAT_EN.
module mac_accumulate_seg
  import mac_const::*;
#(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4*MAC_MIN_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               cfg_mode,
  input  logic [CNT_WIDTH-1:0]     len,
  input  logic [MAC_ACC_WIDTH-1:0] init,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAC_ACC_WIDTH-1:0] acc_in,
  input  logic                     carry_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MAC_ACC_WIDTH-1:0] out,
  output logic [MAC_LANES-1:0]     carry_out,
  output logic                     busy
);

  mac_state_t               state_q, state_d;
  logic [1:0]               mode_q;
  logic [CNT_WIDTH-1:0]     count_q;
  logic [MAC_ACC_WIDTH-1:0] sum_q, add_sum;
  logic [MAC_LANES-1:0]     flags_q, add_carry;
  logic                     beat;

  mac_seg_adder #(.MIN_W(MAC_MIN_WIDTH)) u_adder (
    .a     (sum_q),
    .b     (acc_in),
    .cin   (carry_in),
    .mode  (mode_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign beat = (state_q == ACCUM) && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (beat && count_q == CNT_WIDTH'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MAC_MODE_1X;
      count_q <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        mode_q  <= cfg_mode;
        count_q <= len;
        sum_q   <= init;
        flags_q <= '0;
      end else if (beat) begin
        sum_q   <= add_sum;
        flags_q <= flags_q | add_carry;
        count_q <= count_q - CNT_WIDTH'(1);
      end
    end
  end

  // Handshake outputs are pure decodes of the state flop.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = sum_q;
  assign carry_out = flags_q;

endmodule

// File: doc/mac_accumulate_seg.md
Name: mac_accumulate_seg

Overview:
Next-generation MAC accumulator. Sums a programmed number of operand beats into a register that can be split into 1x32, 2x16 or 4x8 independent lanes. Carries are cut at lane boundaries, and each lane keeps a sticky carry-out flag. Sits after the multiplier array. Valid/ready on both the input and result sides lets it run under the tile controller's backpressure.

Parameters:
MAC_MIN_WIDTH, 8, width of the narrowest lane
MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, accumulator width; must be 4*MAC_MIN_WIDTH
CNT_WIDTH, 16, width of the beat-count field

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a job; sampled only in IDLE
cfg_mode  in  2  00 = 1 lane, 01 = 2 lanes, 10 = 4 lanes, 11 = reserved (treated as 00); latched on start
len  in  CNT_WIDTH  number of input beats; latched on start
init  in  MAC_ACC_WIDTH  initial sum; latched on start
in_valid  in  1  operand beat valid
in_ready  out  1  high in ACCUM only
acc_in  in  MAC_ACC_WIDTH  operand, lane-packed (lane 0 = LSBs)
carry_in  in  1  added into the LSB of lane 0 on each accepted beat
out_valid  out  1  result valid
out_ready  in  1  result accepted
out  out  MAC_ACC_WIDTH  accumulated sum
carry_out  out  4  per-lane sticky carry flags; bit i = lane i; unused lanes read 0
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high). Forces:
  - state = IDLE
  - sum register = 0, flags = 0, count = 0
  - in_ready = 0, out_valid = 0, busy = 0
  - out = 0, carry_out = 0
- Reset mid-job aborts the job; no result is produced.
- IDLE, start = 1:
  - latch cfg_mode and len
  - sum <= init, flags <= 0, count <= len
  - next state is ACCUM, or DONE if len == 0
- ACCUM:
  - in_ready = 1.
  - Each beat with in_valid & in_ready: sum <= segmented_add(sum, acc_in, carry_in).
  - Carries between lanes are cut per the latched mode.
  - Each lane's carry-out is ORed into its flag.
  - count decrements on each beat; the beat that takes count from 1 to 0 moves the FSM to DONE.
  - in_valid low inserts a stall; state and sum are held.
- DONE:
  - out_valid = 1; out = sum; carry_out = flags.
  - Both are held stable until out_ready; on out_valid & out_ready the FSM returns to IDLE.
- Latency:
  - Result is valid the cycle after the last accepted beat.
  - len == 0: result is valid the cycle after start, with out = init and flags = 0.
- start outside IDLE is ignored.
- A new start is accepted in the cycle after the result handshake; there is no overlap with a pending result.
- Arithmetic: unsigned, modulo lane width.
  - Lane i spans bits [(i+1)*W-1 : i*W], where W = MAC_ACC_WIDTH / lanes.
- Outputs are registered.

Optional Feature:
MAC_ACC_SAT_EN
- Defined: a lane whose add carries out is instead forced to all-ones (unsigned saturation), and its flag is set. A saturated lane stays all-ones, because any further nonzero add overflows it again.
- Undefined: lanes wrap modulo 2^W and flags report carry only.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package mac_const:
  - mode encodings: MAC_MODE_1X, MAC_MODE_2X, MAC_MODE_4X
  - lane count 4
  - FSM state encodings IDLE / ACCUM / DONE
- One sub-module: mac_seg_adder.
  - Combinational.
  - Inputs: a, b, cin, mode.
  - Outputs: sum and a 4-bit lane carry vector.
  - Contains the saturation logic under MAC_ACC_SAT_EN.
  - The top level holds the FSM, counter and registers.

Test Plan:
1. Mode 00, init 0, len 3, beats 1, 2, 3 with carry_in 0 -> out 0x00000006, carry_out 0000; out_valid one cycle after the 3rd beat.
2. Mode 10, init 0x000000F0, len 1, acc_in 0x00000020 -> out 0x00000010, carry_out 0001; byte 1 unchanged (no propagation).
3. Mode 01, init 0xFFF00001, len 1, acc_in 0x00200001:
   - default build -> out 0x00100002, carry_out 0010
   - MAC_ACC_SAT_EN build -> out 0xFFFF0002, carry_out 0010
4. Mode 00, len 2, in_valid gapped for 3 cycles, then out_ready low for 5 cycles -> stalls do not change sum; out and carry_out stay stable while out_valid is high; IDLE after the handshake.
5. rst asserted mid-ACCUM after 1 of 4 beats -> immediately in_ready 0, out_valid 0, out 0; next start with init 5, len 0 -> out 5 one cycle later.
6. start pulsed during ACCUM and DONE -> ignored; len and init unchanged; result matches the original job.
